z88_ram_arbiter: RTL and testbench
==================================

Z88_RAM_ARBITER -- requirements
Module: z88_ram_arbiter

Interface
REQ-001 Parameter WAIT_CYC, default 1, SHALL set the number of ACCESS-state cycles per transfer; legal range 1..15.
REQ-002 clk  input  1  system clock; all state SHALL change on its rising edge only.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 cpu_req  input  1  Z80 transfer request, level; held until cpu_ack.
REQ-005 cpu_we  input  1  1 = write, 0 = read; stable while cpu_req is high.
REQ-006 cpu_addr  input  19  Z80 byte address in internal RAM; stable while cpu_req is high.
REQ-007 cpu_wdata  input  8  Z80 write byte.
REQ-008 cpu_ack  output  1  one-cycle completion pulse.
REQ-009 cpu_rdata  output  8  Z80 read byte.
REQ-010 lcd_req  input  1  LCD fetch request, read-only, level; held until lcd_ack.
REQ-011 lcd_addr  input  19  LCD byte address.
REQ-012 lcd_ack  output  1  one-cycle completion pulse.
REQ-013 lcd_rdata  output  8  LCD read byte.
REQ-014 ram_ce_n, ram_oe_n, ram_we_n  output  1 each  SRAM strobes, active-low.
REQ-015 ram_be_n  output  2  byte enables, active-low; bit0 = low byte [7:0], bit1 = high byte [15:8].
REQ-016 ram_addr  output  18  SRAM word address.
REQ-017 ram_wdata  output  16  SRAM write data.
REQ-018 ram_rdata  input  16  SRAM read data.
REQ-019 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-020 FSM states SHALL be IDLE, SETUP, ACCESS and DONE; all outputs SHALL be registered.
REQ-021 IDLE: if neither req is high, stay in IDLE; otherwise latch the winner's owner, we, addr and wdata, then go to SETUP.
REQ-022 Arbitration: a single requester wins. If both are high, the port not granted last wins (round-robin), tracked by a last_grant flag.
REQ-023 SETUP (1 cycle): drive ram_addr = addr[18:1] and ram_ce_n = 0.
REQ-024 SETUP byte enables: addr[0] = 0 -> ram_be_n = 2'b10; addr[0] = 1 -> ram_be_n = 2'b01.
REQ-025 SETUP strobes: for a read, ram_oe_n = 0; for a write, ram_wdata = {wdata, wdata} and ram_oe_n = 1; ram_we_n stays 1.
REQ-026 ACCESS (WAIT_CYC cycles, 4-bit down-counter): for a write, ram_we_n = 0. Address, be_n and data SHALL stay stable.
REQ-027 ACCESS exit: on the last ACCESS cycle, capture the selected byte (addr[0] ? ram_rdata[15:8] : ram_rdata[7:0]) for a read, then go to DONE.
REQ-028 DONE (1 cycle): ram_we_n = 1, ram_oe_n = 1, ram_ce_n = 1, ram_be_n = 2'b11.
REQ-029 DONE: pulse the owner's ack for exactly this cycle and present the read byte on the owner's rdata; update last_grant; go to IDLE.
REQ-030 rdata hold: cpu_rdata and lcd_rdata SHALL hold their value until that port's next read ack. A CPU write SHALL NOT alter cpu_rdata.
REQ-031 Latency: for req sampled high in IDLE at edge N with no contention, ack SHALL be high in cycle N+2+WAIT_CYC; the transfer occupies 3+WAIT_CYC cycles, including the IDLE cycle.
REQ-032 Requests arriving while busy SHALL wait; the next IDLE SHALL grant the waiting port. Worst-case wait is one foreign transfer plus the port's own.
REQ-033 Back-to-back: a requester keeping req high after its ack SHALL be treated as a new request in the following IDLE cycle and is subject to round-robin.
REQ-034 Changes on req, addr, we or wdata after the IDLE latch SHALL NOT affect the transfer in progress.
REQ-035 cpu_ack and lcd_ack SHALL never be high in the same cycle, and ram_we_n and ram_oe_n SHALL never be low simultaneously.
REQ-036 WAIT_CYC outside 1..15 is unsupported; no behaviour is defined for it.

Reset
REQ-037 On rst high, asynchronously and with no clock edge needed:
- state = IDLE, busy = 0, cpu_ack = lcd_ack = 0
- ram_ce_n = ram_oe_n = ram_we_n = 1, ram_be_n = 2'b11
- ram_addr = 0, ram_wdata = 0, cpu_rdata = lcd_rdata = 0
- last_grant = LCD, so the CPU wins the first tie
REQ-038 Reset mid-transfer SHALL abort with no ack issued and strobes deasserted. After release, the first edge SHALL evaluate requests in IDLE.

Verification
REQ-039 WAIT_CYC=1, CPU read of 0x00003 with ram_rdata = 16'hA55A:
- ram_be_n = 01, ram_addr = 1
- cpu_ack at N+3, cpu_rdata = 8'hA5
REQ-040 CPU write of 0x7C at 0x10000:
- ram_addr = 0x8000, ram_be_n = 10, ram_wdata = 16'h7C7C
- ram_we_n low exactly during ACCESS, ram_oe_n high throughout
REQ-041 cpu_req and lcd_req rise on the same edge, both held after ack:
- grants alternate CPU, LCD, CPU, LCD
- no double ack; busy drops to 0 for exactly one cycle between transfers
REQ-042 WAIT_CYC=4, LCD read:
- ACCESS lasts 4 cycles, lcd_ack at N+6
- lcd_rdata = byte at lcd_addr; cpu_rdata unchanged
REQ-043 rst pulsed during ACCESS of a CPU write:
- ram_we_n and ram_ce_n go to 1 immediately, no cpu_ack
- with cpu_req still high after release, a new transfer completes normally

Source files
------------

// File: rtl/z88_ram_arbiter.sv
// z88_ram_arbiter: two-port (Z80 CPU, LCD fetch) round-robin arbiter onto a 16-bit async SRAM.
// Ports: clk/rst (async, active-high); cpu_req/we/addr/wdata -> cpu_ack/rdata; lcd_req/addr -> lcd_ack/rdata;
// ram_ce_n/oe_n/we_n/be_n/addr/wdata -> SRAM, ram_rdata <- SRAM; busy = FSM not in IDLE.
module z88_ram_arbiter #(
  parameter int WAIT_CYC = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [18:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  input  logic        lcd_req,
  input  logic [18:0] lcd_addr,
  output logic        lcd_ack,
  output logic [7:0]  lcd_rdata,
  output logic        ram_ce_n,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  output logic [1:0]  ram_be_n,
  output logic [17:0] ram_addr,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
  state_t state, nxt;
  logic own, we, a0, last_grant;
  logic [3:0] cnt;
  logic any_req, pick_lcd, sel_we;
  logic [18:0] sel_addr;
  logic [7:0] byte_in;
  assign any_req  = cpu_req | lcd_req;
  // own/last_grant: 1 = LCD; on a tie the port not served last wins
  assign pick_lcd = lcd_req & (~cpu_req | ~last_grant);
  assign sel_addr = pick_lcd ? lcd_addr : cpu_addr;
  assign sel_we   = ~pick_lcd & cpu_we;
  assign byte_in  = a0 ? ram_rdata[15:8] : ram_rdata[7:0];
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = any_req ? SETUP : IDLE;
      SETUP:   nxt = ACCESS;
      ACCESS:  nxt = (cnt == 4'd0) ? DONE : ACCESS;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  // Outputs are loaded on the edge that enters each state, so they are valid for the whole state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      own        <= 1'b0;
      we         <= 1'b0;
      a0         <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= 4'd0;
      busy       <= 1'b0;
      cpu_ack    <= 1'b0;
      lcd_ack    <= 1'b0;
      ram_ce_n   <= 1'b1;
      ram_oe_n   <= 1'b1;
      ram_we_n   <= 1'b1;
      ram_be_n   <= 2'b11;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      cpu_rdata  <= '0;
      lcd_rdata  <= '0;
    end else begin
      busy    <= nxt != IDLE;
      cpu_ack <= 1'b0;
      lcd_ack <= 1'b0;
      case (state)
        IDLE: if (any_req) begin
          own      <= pick_lcd;
          we       <= sel_we;
          a0       <= sel_addr[0];
          ram_addr <= sel_addr[18:1];
          ram_be_n <= sel_addr[0] ? 2'b01 : 2'b10;
          ram_ce_n <= 1'b0;
          ram_oe_n <= sel_we;
          if (sel_we) ram_wdata <= {cpu_wdata, cpu_wdata};
        end
        SETUP: begin
          cnt      <= 4'(WAIT_CYC - 1);
          ram_we_n <= ~we;
        end
        ACCESS: if (cnt == 4'd0) begin
          ram_ce_n <= 1'b1;
          ram_oe_n <= 1'b1;
          ram_we_n <= 1'b1;
          ram_be_n <= 2'b11;
          cpu_ack  <= ~own;
          lcd_ack  <= own;
          if (!own && !we) cpu_rdata <= byte_in;
          if (own) lcd_rdata <= byte_in;
        end else cnt <= cnt - 4'd1;
        DONE: last_grant <= own;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_z88_ram_arbiter.sv
// tb_z88_ram_arbiter: self-checking bench; u1 runs WAIT_CYC=1, u4 runs WAIT_CYC=4, SRAM is a combinational pattern.
module tb_z88_ram_arbiter;
  logic clk = 0, rst = 1;
  int errors = 0, checks = 0;
  logic cpu_req = 0, cpu_we = 0, lcd_req = 0;
  logic [18:0] cpu_addr = 0, lcd_addr = 0;
  logic [7:0] cpu_wdata = 0, cpu_rdata, lcd_rdata;
  logic cpu_ack, lcd_ack, ram_ce_n, ram_oe_n, ram_we_n, busy;
  logic [1:0] ram_be_n;
  logic [17:0] ram_addr;
  logic [15:0] ram_wdata, ram_rdata, force_val = 0;
  logic force_en = 0;
  logic w4_cpu_req = 0, w4_cpu_we = 0, w4_lcd_req = 0;
  logic [18:0] w4_cpu_addr = 0, w4_lcd_addr = 0;
  logic [7:0] w4_cpu_wdata = 0, w4_cpu_rdata, w4_lcd_rdata;
  logic w4_cpu_ack, w4_lcd_ack, w4_ram_ce_n, w4_ram_oe_n, w4_ram_we_n, w4_busy;
  logic [1:0] w4_ram_be_n;
  logic [17:0] w4_ram_addr;
  logic [15:0] w4_ram_wdata, w4_ram_rdata;

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [17:0] w);
    return {w[7:0] ^ w[17:10], w[9:2] + 8'h3C};
  endfunction
  function automatic logic [7:0] mem_byte(input logic [18:0] a);
    logic [15:0] w;
    w = mem_word(a[18:1]);
    return a[0] ? w[15:8] : w[7:0];
  endfunction

  assign ram_rdata    = force_en ? force_val : mem_word(ram_addr);
  assign w4_ram_rdata = mem_word(w4_ram_addr);

  z88_ram_arbiter #(.WAIT_CYC(1)) u1 (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .lcd_req(lcd_req),
    .lcd_addr(lcd_addr), .lcd_ack(lcd_ack), .lcd_rdata(lcd_rdata), .ram_ce_n(ram_ce_n),
    .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n), .ram_be_n(ram_be_n), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy));

  z88_ram_arbiter #(.WAIT_CYC(4)) u4 (
    .clk(clk), .rst(rst), .cpu_req(w4_cpu_req), .cpu_we(w4_cpu_we), .cpu_addr(w4_cpu_addr),
    .cpu_wdata(w4_cpu_wdata), .cpu_ack(w4_cpu_ack), .cpu_rdata(w4_cpu_rdata), .lcd_req(w4_lcd_req),
    .lcd_addr(w4_lcd_addr), .lcd_ack(w4_lcd_ack), .lcd_rdata(w4_lcd_rdata), .ram_ce_n(w4_ram_ce_n),
    .ram_oe_n(w4_ram_oe_n), .ram_we_n(w4_ram_we_n), .ram_be_n(w4_ram_be_n), .ram_addr(w4_ram_addr),
    .ram_wdata(w4_ram_wdata), .ram_rdata(w4_ram_rdata), .busy(w4_busy));

  task automatic cyc;
    @(negedge clk);
  endtask

  task automatic apply_reset;
    rst = 1; cpu_req = 0; lcd_req = 0; w4_cpu_req = 0; w4_lcd_req = 0;
    cyc(); cyc();
    rst = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    cyc();
    checks++; if ({busy, cpu_ack, lcd_ack} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {busy, cpu_ack, lcd_ack}); end
    checks++; if ({ram_ce_n, ram_oe_n, ram_we_n, ram_be_n} !== 5'b11111) begin errors++; $display("FAIL reset_strobes got %b exp 11111", {ram_ce_n, ram_oe_n, ram_we_n, ram_be_n}); end
    checks++; if ({ram_addr, ram_wdata, cpu_rdata, lcd_rdata} !== 50'd0) begin errors++; $display("FAIL reset_data got %h exp 0", {ram_addr, ram_wdata, cpu_rdata, lcd_rdata}); end
    checks++; if ({w4_busy, w4_ram_ce_n, w4_ram_be_n, w4_ram_wdata} !== {1'b0, 1'b1, 2'b11, 16'h0}) begin errors++; $display("FAIL reset_u4 got %b", {w4_busy, w4_ram_ce_n, w4_ram_be_n}); end
    apply_reset();
  endtask

  task automatic test_read;
    force_en = 1; force_val = 16'hA55A;
    cpu_req = 1; cpu_we = 0; cpu_addr = 19'h00003;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      checks++; if (cpu_ack !== (k == 3)) begin errors++; $display("FAIL read_ack k=%0d got %b exp %b", k, cpu_ack, k == 3); end
      checks++; if (busy !== (k < 4)) begin errors++; $display("FAIL read_busy k=%0d got %b exp %b", k, busy, k < 4); end
      if (k < 3) begin
        checks++; if ({ram_addr, ram_be_n, ram_ce_n, ram_oe_n, ram_we_n} !== {18'd1, 2'b01, 3'b001}) begin errors++; $display("FAIL read_bus k=%0d got addr=%h be=%b ce/oe/we=%b", k, ram_addr, ram_be_n, {ram_ce_n, ram_oe_n, ram_we_n}); end
      end
      if (k == 3) begin
        checks++; if (cpu_rdata !== 8'hA5) begin errors++; $display("FAIL read_data got %h exp a5", cpu_rdata); end
        checks++; if ({ram_ce_n, ram_oe_n, ram_we_n, ram_be_n} !== 5'b11111) begin errors++; $display("FAIL read_done_strobes got %b exp 11111", {ram_ce_n, ram_oe_n, ram_we_n, ram_be_n}); end
        cpu_req = 0;
      end
    end
    checks++; if (cpu_rdata !== 8'hA5) begin errors++; $display("FAIL read_hold got %h exp a5", cpu_rdata); end
    force_en = 0;
  endtask

  task automatic test_write;
    cpu_req = 1; cpu_we = 1; cpu_addr = 19'h10000; cpu_wdata = 8'h7C;
    for (int k = 1; k <= 3; k++) begin
      cyc();
      checks++; if (cpu_ack !== (k == 3)) begin errors++; $display("FAIL write_ack k=%0d got %b exp %b", k, cpu_ack, k == 3); end
      checks++; if (ram_we_n !== (k != 2)) begin errors++; $display("FAIL write_we_n k=%0d got %b exp %b", k, ram_we_n, k != 2); end
      checks++; if (ram_oe_n !== 1'b1) begin errors++; $display("FAIL write_oe_n k=%0d got %b exp 1", k, ram_oe_n); end
      if (k < 3) begin
        checks++; if ({ram_addr, ram_be_n, ram_wdata} !== {18'h08000, 2'b10, 16'h7C7C}) begin errors++; $display("FAIL write_bus k=%0d got addr=%h be=%b wd=%h", k, ram_addr, ram_be_n, ram_wdata); end
      end
      if (k == 1) begin
        cpu_addr = 19'($urandom); cpu_wdata = 8'hFF; cpu_we = 0;
      end
      if (k == 3) begin
        checks++; if (cpu_rdata !== 8'hA5) begin errors++; $display("FAIL write_keeps_rdata got %h exp a5", cpu_rdata); end
        cpu_req = 0;
      end
    end
  endtask

  task automatic test_round_robin;
    int order[4];
    int at[4];
    int n = 0;
    bit prev_ack = 0;
    logic [7:0] exp_l;
    apply_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 19'($urandom); lcd_addr = 19'($urandom);
    lcd_req = 1;
    exp_l = mem_byte(lcd_addr);
    for (int c = 1; c <= 40 && n < 4; c++) begin
      cyc();
      checks++; if (cpu_ack && lcd_ack) begin errors++; $display("FAIL rr_double_ack c=%0d got 11 exp not both", c); end
      checks++; if (busy !== !prev_ack) begin errors++; $display("FAIL rr_busy c=%0d got %b exp %b", c, busy, !prev_ack); end
      prev_ack = cpu_ack | lcd_ack;
      if (prev_ack) begin
        order[n] = lcd_ack ? 1 : 0; at[n] = c;
        if (lcd_ack) begin
          checks++; if (lcd_rdata !== exp_l) begin errors++; $display("FAIL rr_lcd_rdata got %h exp %h", lcd_rdata, exp_l); end
        end
        n++;
        if (n == 4) begin cpu_req = 0; lcd_req = 0; end
      end
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL rr_timeout got %0d acks exp 4", n); cpu_req = 0; lcd_req = 0; end
    for (int i = 0; i < n; i++) begin
      checks++; if (order[i] !== i % 2 || at[i] !== 3 + 4 * i) begin errors++; $display("FAIL rr_order i=%0d got port=%0d cyc=%0d exp port=%0d cyc=%0d", i, order[i], at[i], i % 2, 3 + 4 * i); end
    end
    cyc();
  endtask

  task automatic test_wait4;
    w4_lcd_req = 1; w4_lcd_addr = 19'h2ABCD;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      checks++; if (w4_lcd_ack !== (k == 6) || w4_cpu_ack !== 1'b0) begin errors++; $display("FAIL w4_ack k=%0d got lcd=%b cpu=%b exp lcd=%b", k, w4_lcd_ack, w4_cpu_ack, k == 6); end
      if (k < 6) begin
        checks++; if ({w4_ram_ce_n, w4_ram_oe_n, w4_ram_we_n, w4_ram_addr} !== {3'b001, 18'h155E6}) begin errors++; $display("FAIL w4_bus k=%0d got strobes=%b addr=%h", k, {w4_ram_ce_n, w4_ram_oe_n, w4_ram_we_n}, w4_ram_addr); end
      end
      if (k == 6) begin
        checks++; if (w4_lcd_rdata !== mem_byte(19'h2ABCD)) begin errors++; $display("FAIL w4_rdata got %h exp %h", w4_lcd_rdata, mem_byte(19'h2ABCD)); end
        checks++; if (w4_cpu_rdata !== 8'h00) begin errors++; $display("FAIL w4_cpu_rdata got %h exp 00", w4_cpu_rdata); end
        w4_lcd_req = 0;
      end
    end
  endtask

  task automatic test_reset_mid;
    cpu_req = 1; cpu_we = 1; cpu_addr = 19'($urandom); cpu_wdata = 8'($urandom);
    cyc(); cyc();
    checks++; if (ram_we_n !== 1'b0) begin errors++; $display("FAIL mid_pre_we_n got %b exp 0", ram_we_n); end
    #1 rst = 1;
    #1;
    checks++; if ({ram_we_n, ram_ce_n, busy, cpu_ack} !== 4'b1100) begin errors++; $display("FAIL mid_async got we/ce/busy/ack=%b exp 1100", {ram_we_n, ram_ce_n, busy, cpu_ack}); end
    cyc(); cyc();
    checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL mid_no_ack got %b exp 0", cpu_ack); end
    rst = 0;
    for (int k = 1; k <= 3; k++) begin
      cyc();
      checks++; if (cpu_ack !== (k == 3)) begin errors++; $display("FAIL mid_restart_ack k=%0d got %b exp %b", k, cpu_ack, k == 3); end
      checks++; if (ram_we_n !== (k != 2)) begin errors++; $display("FAIL mid_restart_we_n k=%0d got %b exp %b", k, ram_we_n, k != 2); end
    end
    cpu_req = 0;
  endtask

  task automatic test_random;
    int dec = 0, gnt_c = -1, ack_c = -1;
    bit cpu_p = 0, lcd_p = 0, own_lcd = 0, lg_lcd = 1, exp_we = 0;
    logic [7:0] exp_byte = 0, exp_c = 0, exp_l = 0;
    logic [18:0] a;
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) cyc();
      if (c == ack_c) begin
        if (own_lcd) begin exp_l = exp_byte; lcd_p = 0; end
        else begin if (!exp_we) exp_c = exp_byte; cpu_p = 0; end
        lg_lcd = own_lcd;
      end
      checks++; if (cpu_ack !== (c == ack_c && !own_lcd) || lcd_ack !== (c == ack_c && own_lcd)) begin errors++; $display("FAIL rnd_ack c=%0d got cpu=%b lcd=%b exp cpu=%b lcd=%b", c, cpu_ack, lcd_ack, c == ack_c && !own_lcd, c == ack_c && own_lcd); end
      checks++; if (busy !== (c > gnt_c && c <= ack_c)) begin errors++; $display("FAIL rnd_busy c=%0d got %b exp %b", c, busy, c > gnt_c && c <= ack_c); end
      checks++; if (cpu_rdata !== exp_c || lcd_rdata !== exp_l) begin errors++; $display("FAIL rnd_rdata c=%0d got cpu=%h lcd=%h exp cpu=%h lcd=%h", c, cpu_rdata, lcd_rdata, exp_c, exp_l); end
      checks++; if (!ram_we_n && !ram_oe_n) begin errors++; $display("FAIL rnd_strobe_clash c=%0d got we_n=0 oe_n=0 exp not both low", c); end
      if (!cpu_p) begin
        cpu_p = $urandom_range(0, 2) == 0;
        cpu_req = cpu_p; cpu_we = 1'($urandom); cpu_addr = 19'($urandom); cpu_wdata = 8'($urandom);
      end
      if (!lcd_p) begin
        lcd_p = $urandom_range(0, 2) == 0;
        lcd_req = lcd_p; lcd_addr = 19'($urandom);
      end
      if (c == dec) begin
        if (cpu_p || lcd_p) begin
          own_lcd = lcd_p && (!cpu_p || !lg_lcd);
          exp_we = !own_lcd && cpu_we;
          a = own_lcd ? lcd_addr : cpu_addr;
          exp_byte = mem_byte(a);
          gnt_c = c; ack_c = c + 3; dec = c + 4;
        end else dec = c + 1;
      end
    end
    cpu_req = 0; lcd_req = 0;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_round_robin();
    test_wait4();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
